// File: rtl/rot_pkg.sv
// Shared constants for the rotary encoder front end: quadrature codes, detent thresholds, sub-count type.
// Build option ROT_HALFSTEP_EN selects two detents per Gray cycle (at 00 and 11) with threshold +/-2.
package rot_pkg;

   localparam logic [1:0] ROT_C00 = 2'b00;
   localparam logic [1:0] ROT_C10 = 2'b10;
   localparam logic [1:0] ROT_C11 = 2'b11;
   localparam logic [1:0] ROT_C01 = 2'b01;

   // One bit wider than a bare 3-bit signed value so that +4 is representable.
   localparam int SUB_W   = 4;
   localparam int SUB_SAT = 4;
`ifdef ROT_HALFSTEP_EN
   localparam int DETENT_TH = 2;
`else
   localparam int DETENT_TH = 4;
`endif

   typedef logic signed [SUB_W-1:0] sub_t;

   typedef enum logic [1:0] {
      ST_00 = ROT_C00,
      ST_10 = ROT_C10,
      ST_11 = ROT_C11,
      ST_01 = ROT_C01
   } rot_state_e;

   typedef enum logic [1:0] {QD_HOLD, QD_FWD, QD_REV, QD_ILL} quad_dir_e;

   // Clockwise successor in the Gray sequence 00->10->11->01->00.
   function automatic logic [1:0] rot_fwd(input logic [1:0] c);
      logic [1:0] n;
      case (c)
         ROT_C00: n = ROT_C10;
         ROT_C10: n = ROT_C11;
         ROT_C11: n = ROT_C01;
         default: n = ROT_C00;
      endcase
      return n;
   endfunction

   function automatic quad_dir_e rot_classify(input logic [1:0] prev, input logic [1:0] cur);
      quad_dir_e d;
      if (cur == prev)               d = QD_HOLD;
      else if (cur == rot_fwd(prev)) d = QD_FWD;
      else if (prev == rot_fwd(cur)) d = QD_REV;
      else                           d = QD_ILL;
      return d;
   endfunction

endpackage

// File: rtl/rot_filter.sv
// Two-flop synchroniser followed by a stability filter: the output level follows the
// synchronised pin only after it has differed for FILT_CYCLES consecutive cycles.
module rot_filter #(
   parameter int FILT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level
);

   localparam int CNT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync  <= 2'b00;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync <= {sync[0], pin};
         // Any sample agreeing with the current level restarts the stability window.
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/rot_decoder.sv
// Rotary encoder front end: filtered quadrature decode into detent pulses, wrapping position and centre press.
// Build option ROT_HALFSTEP_EN: detents at both 00 and 11 (two steps per Gray cycle).
module rot_decoder
   import rot_pkg::*;
#(
   parameter int FILT_CYCLES = 16,
   parameter int POS_W       = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rot_a,
   input  logic             rot_b,
   input  logic             rot_ctr,
   output logic             step_next,
   output logic             step_prev,
   output logic [POS_W-1:0] pos,
   output logic             ctr_level,
   output logic             ctr_press,
   output logic             err
);

   logic       a_f, b_f;
   logic [1:0] code;
   logic       ctr_level_d;

   rot_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_a   (.clk(clk), .rst(rst), .pin(rot_a),   .level(a_f));
   rot_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_b   (.clk(clk), .rst(rst), .pin(rot_b),   .level(b_f));
   rot_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_ctr (.clk(clk), .rst(rst), .pin(rot_ctr), .level(ctr_level));

   assign code = {a_f, b_f};

   rot_state_e state_q, state_d;
   sub_t       sub_q, sub_d, sub_upd;
   quad_dir_e  dir;
   logic       detent;
   logic       next_d, prev_d, err_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_00;
         sub_q   <= '0;
      end else begin
         state_q <= state_d;
         sub_q   <= sub_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sub_d   = sub_q;
      sub_upd = sub_q;
      next_d  = 1'b0;
      prev_d  = 1'b0;
      err_d   = 1'b0;
      dir     = rot_classify(state_q, code);
`ifdef ROT_HALFSTEP_EN
      detent  = (code == ROT_C00) || (code == ROT_C11);
`else
      detent  = (code == ROT_C00);
`endif
      case (dir)
         QD_ILL: begin
            err_d   = 1'b1;
            sub_d   = '0;
            state_d = rot_state_e'(code);
         end
         QD_FWD, QD_REV: begin
            if (dir == QD_FWD)
               sub_upd = (sub_q >= sub_t'(SUB_SAT)) ? sub_q : sub_q + sub_t'(1);
            else
               sub_upd = (sub_q <= sub_t'(-SUB_SAT)) ? sub_q : sub_q - sub_t'(1);
            state_d = rot_state_e'(code);
            // A detent only counts when the whole half/full cycle was traversed in one direction.
            if (detent) begin
               next_d = (sub_upd == sub_t'(DETENT_TH));
               prev_d = (sub_upd == sub_t'(-DETENT_TH));
               sub_d  = '0;
            end else begin
               sub_d  = sub_upd;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step_next   <= 1'b0;
         step_prev   <= 1'b0;
         err         <= 1'b0;
         pos         <= '0;
         ctr_level_d <= 1'b0;
         ctr_press   <= 1'b0;
      end else begin
         step_next   <= next_d;
         step_prev   <= prev_d;
         err         <= err_d;
         if (next_d)
            pos <= pos + POS_W'(1);
         else if (prev_d)
            pos <= pos - POS_W'(1);
         ctr_level_d <= ctr_level;
         ctr_press   <= ctr_level & ~ctr_level_d;
      end
   end

endmodule

// File: tb/tb_rot_decoder.sv
// Directed plus random-walk bench for rot_decoder; expectations come from a detent-index model
// that counts quarter turns around the Gray cycle with plain modular arithmetic.
module tb_rot_decoder;

   localparam int POS_W = 5;
   localparam int PMOD  = 1 << POS_W;
`ifdef ROT_HALFSTEP_EN
   localparam int TH   = 2;
   localparam bit HALF = 1'b1;
`else
   localparam int TH   = 4;
   localparam bit HALF = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             rot_a = 1'b0, rot_b = 1'b0, rot_ctr = 1'b0;
   logic             step_next, step_prev, ctr_level, ctr_press, err;
   logic [POS_W-1:0] pos;

   always #5 clk = ~clk;

   rot_decoder #(.FILT_CYCLES(16), .POS_W(POS_W)) dut (
      .clk(clk), .rst(rst), .rot_a(rot_a), .rot_b(rot_b), .rot_ctr(rot_ctr),
      .step_next(step_next), .step_prev(step_prev), .pos(pos),
      .ctr_level(ctr_level), .ctr_press(ctr_press), .err(err)
   );

   int tests = 0;
   int fails = 0;

   // Pulse monitor: cumulative totals, sampled mid-cycle.
   int tot_next = 0, tot_prev = 0, tot_err = 0, tot_press = 0, tot_both = 0;
   always @(negedge clk) begin
      if (rst) begin
         tot_next  += int'(step_next);
         tot_prev  += int'(step_prev);
         tot_err   += int'(err);
         tot_press += int'(ctr_press);
         tot_both  += int'(step_next & step_prev);
      end
   end

   // Reference model: position in the Gray cycle as an index 0..3 (00,10,11,01).
   int   m_idx, m_sub, m_pos;
   logic m_ctr;
   int   e_next, e_prev, e_err, e_press;
   int   b_next, b_prev, b_err, b_press;
   logic [POS_W-1:0] exp_q[$];

   function automatic int code_idx(input logic [1:0] c);
      case (c)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] idx_code(input int i);
      case (i)
         0:       return 2'b00;
         1:       return 2'b10;
         2:       return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   task automatic model_reset();
      m_idx = 0; m_sub = 0; m_pos = 0; m_ctr = 1'b0;
   endtask

   task automatic model_code(input logic [1:0] c);
      int ni, d;
      ni = code_idx(c);
      d  = (ni - m_idx + 4) % 4;
      if (d == 2) begin
         e_err++;
         m_sub = 0;
      end else if (d != 0) begin
         m_sub += (d == 1) ? 1 : -1;
         if (m_sub > 4)  m_sub = 4;
         if (m_sub < -4) m_sub = -4;
         if (ni == 0 || (HALF && ni == 2)) begin
            if (m_sub == TH) begin
               e_next++;
               m_pos = (m_pos + 1) % PMOD;
            end else if (m_sub == -TH) begin
               e_prev++;
               m_pos = (m_pos + PMOD - 1) % PMOD;
            end
            m_sub = 0;
         end
      end
      m_idx = ni;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic open_window();
      b_next = tot_next; b_prev = tot_prev; b_err = tot_err; b_press = tot_press;
      e_next = 0; e_prev = 0; e_err = 0; e_press = 0;
   endtask

   task automatic close_window(input string tag);
      logic [POS_W-1:0] ep;
      check({tag, "_next"},  tot_next  - b_next,  e_next);
      check({tag, "_prev"},  tot_prev  - b_prev,  e_prev);
      check({tag, "_err"},   tot_err   - b_err,   e_err);
      check({tag, "_press"}, tot_press - b_press, e_press);
      exp_q.push_back(POS_W'(m_pos));
      ep = exp_q.pop_front();
      check({tag, "_pos"}, int'(pos), int'(ep));
      check({tag, "_ctr_level"}, int'(ctr_level), int'(m_ctr));
   endtask

   // Move the encoder inputs to code c, optionally with contact bounce on the changing pin.
   task automatic drive(input string tag, input logic [1:0] c, input bit bounce, input bit ctr_flip);
      logic [1:0] old;
      old = {rot_a, rot_b};
      open_window();
      if (bounce && $onehot(c ^ old)) begin
         repeat ($urandom_range(1, 4)) begin
            {rot_a, rot_b} = c;
            wait_cyc($urandom_range(1, 10));
            {rot_a, rot_b} = old;
            wait_cyc($urandom_range(1, 10));
         end
      end
      {rot_a, rot_b} = c;
      if (ctr_flip) rot_ctr = ~rot_ctr;
      wait_cyc(40);
      model_code(c);
      if (ctr_flip) begin
         if (rot_ctr) e_press++;
         m_ctr = rot_ctr;
      end
      close_window(tag);
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check({tag, "_step_next"}, int'(step_next), 0);
      check({tag, "_step_prev"}, int'(step_prev), 0);
      check({tag, "_pos"},       int'(pos),       0);
      check({tag, "_ctr_level"}, int'(ctr_level), 0);
      check({tag, "_ctr_press"}, int'(ctr_press), 0);
      check({tag, "_err"},       int'(err),       0);
      rot_a = 1'b0; rot_b = 1'b0; rot_ctr = 1'b0;
      wait_cyc(5);
      @(negedge clk);
      rst = 1'b1;
      wait_cyc(2);
      model_reset();
   endtask

   initial begin
      int r;
      logic [1:0] nc;
      model_reset();

      do_reset("rst0");

      drive("cw_10", 2'b10, 1'b0, 1'b0);
      drive("cw_11", 2'b11, 1'b0, 1'b0);
      drive("cw_01", 2'b01, 1'b0, 1'b0);
      drive("cw_00", 2'b00, 1'b0, 1'b0);
      check("cw_pos_abs", int'(pos), HALF ? 2 : 1);

      do_reset("rst1");
      drive("ccw_01", 2'b01, 1'b0, 1'b0);
      drive("ccw_11", 2'b11, 1'b0, 1'b0);
      drive("ccw_10", 2'b10, 1'b0, 1'b0);
      drive("ccw_00", 2'b00, 1'b0, 1'b0);
      check("ccw_pos_abs", int'(pos), HALF ? 30 : 31);

      open_window();
      for (int i = 0; i < 12; i++) begin
         rot_a = ~rot_a;
         wait_cyc(5);
      end
      wait_cyc(40);
      close_window("bounce");

      drive("ill_11", 2'b11, 1'b0, 1'b0);
      drive("ill_01", 2'b01, 1'b0, 1'b0);
      drive("ill_00", 2'b00, 1'b0, 1'b0);

      drive("rev_10",  2'b10, 1'b0, 1'b0);
      drive("rev_11",  2'b11, 1'b0, 1'b0);
      drive("rev_10b", 2'b10, 1'b0, 1'b0);
      drive("rev_00",  2'b00, 1'b0, 1'b0);

      drive("ctr_on", {rot_a, rot_b}, 1'b0, 1'b1);

      drive("mid_10", 2'b10, 1'b0, 1'b0);
      drive("mid_11", 2'b11, 1'b0, 1'b0);
      do_reset("rst_mid");
      drive("cw2_10", 2'b10, 1'b0, 1'b0);
      drive("cw2_11", 2'b11, 1'b0, 1'b0);
      drive("cw2_01", 2'b01, 1'b0, 1'b0);
      drive("cw2_00", 2'b00, 1'b0, 1'b0);
      check("cw2_pos_abs", int'(pos), HALF ? 2 : 1);

      for (int i = 0; i < 60; i++) begin
         r = int'($urandom_range(0, 9));
         if (r <= 4)      nc = idx_code((m_idx + 1) % 4);
         else if (r <= 7) nc = idx_code((m_idx + 3) % 4);
         else if (r == 8) nc = idx_code(m_idx);
         else             nc = idx_code((m_idx + 2) % 4);
         drive("rnd", nc, bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end

      check("never_both", tot_both, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
